mem_ctrl: RTL and testbench

Memory controller for the LC-3 Patt CPU. It owns MAR, MDR, address-control logic and the memory-mapped device registers (KBSR, KBDR, DSR, DDR, MCR). It sequences fixed-latency accesses to an external synchronous SRAM and drives the CPU's R (mem_rdy) handshake. It sits on the shared 16-bit bus beside the cpu module and consumes its LD.MAR, LD.MDR, MIO.EN, R.W and GateMDR controls.

---
 rtl/mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// LC-3 memory controller: MAR/MDR, address decode, memory-mapped device
// registers and fixed-latency SRAM access sequencing with the R handshake.
module mem_ctrl #(
  parameter int unsigned MEM_LATENCY = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire  [15:0] bus,
  input  logic        gate_mdr,
  input  logic        mem_ld_mar,
  input  logic        mem_ld_mdr,
  input  logic        mem_mio_en,
  input  logic        mem_rw,
  output logic        mem_rdy,
  output logic        sram_en,
  output logic        sram_we,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack,
  output logic        kb_irq,
  output logic        disp_irq,
  output logic        mcr_run
);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;
  localparam logic [3:0]  LAT_M1    = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        rdy_q, we_q;
  logic [15:0] mar_q, mdr_q, rdata_q, rdata_d;
  logic [15:0] kbdr_q, ddr_q, mcr_q;
  logic        kb_full_q, kb_ie_q, ds_rdy_q, ds_ie_q, disp_valid_q;

  logic is_dev, fire, wr_fire, kb_clr;

  assign is_dev  = (mar_q[15:9] == 7'h7F);
  assign fire    = (state_q == WAIT) && mem_mio_en && (cnt_q == 4'd0);
  assign wr_fire = fire && mem_rw;
  assign kb_clr  = fire && !mem_rw && (mar_q == ADDR_KBDR);

  always_comb begin
    rdata_d = '0;
    if (!is_dev) begin
      rdata_d = sram_rdata;
    end else begin
      case (mar_q)
        ADDR_KBSR: rdata_d = {kb_full_q, kb_ie_q, 14'h0};
        ADDR_KBDR: rdata_d = kbdr_q;
        ADDR_DSR:  rdata_d = {ds_rdy_q, ds_ie_q, 14'h0};
        ADDR_DDR:  rdata_d = ddr_q;
        ADDR_MCR:  rdata_d = mcr_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  // Read data is snapshotted on the completing edge so a KBDR read returns
  // the character present when KBSR[15] is cleared, even if a new one lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_mio_en) begin
            state_q <= WAIT;
            cnt_q   <= LAT_M1;
          end
        end
        WAIT: begin
          if (!mem_mio_en) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= READY;
            rdy_q   <= 1'b1;
            we_q    <= mem_rw && !is_dev;
            rdata_q <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        READY: begin
          if (!mem_mio_en) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      if (mem_ld_mar) mar_q <= bus;
      if (mem_ld_mdr) begin
        if (!mem_mio_en || mem_rw) mdr_q <= bus;
        else if (rdy_q)            mdr_q <= rdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbdr_q       <= '0;
      kb_full_q    <= 1'b0;
      kb_ie_q      <= 1'b0;
      ddr_q        <= '0;
      disp_valid_q <= 1'b0;
      ds_rdy_q     <= 1'b1;
      ds_ie_q      <= 1'b0;
      mcr_q        <= 16'h8000;
    end else begin
      if (kb_valid && (!kb_full_q || kb_clr)) begin
        kbdr_q    <= {8'h00, kb_data};
        kb_full_q <= 1'b1;
      end else if (kb_clr) begin
        kb_full_q <= 1'b0;
      end
      if (wr_fire && mar_q == ADDR_KBSR) kb_ie_q <= mdr_q[14];
      if (wr_fire && mar_q == ADDR_DSR)  ds_ie_q <= mdr_q[14];
      if (wr_fire && mar_q == ADDR_MCR)  mcr_q   <= mdr_q;
      if (wr_fire && mar_q == ADDR_DDR) begin
        ddr_q        <= mdr_q;
        disp_valid_q <= 1'b1;
        ds_rdy_q     <= 1'b0;
      end else if (disp_ack && disp_valid_q) begin
        disp_valid_q <= 1'b0;
        ds_rdy_q     <= 1'b1;
      end
    end
  end

  assign bus        = gate_mdr ? mdr_q : 'z;
  assign mem_rdy    = rdy_q;
  assign sram_en    = (state_q != IDLE) && !is_dev;
  assign sram_we    = we_q;
  assign sram_addr  = mar_q;
  assign sram_wdata = mdr_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = ddr_q[7:0];
  assign kb_irq     = kb_full_q & kb_ie_q;
  assign disp_irq   = ds_rdy_q & ds_ie_q;
  assign mcr_run    = mcr_q[15];

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: transaction-level model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_mem_ctrl;
  localparam int L = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        gate_mdr = 0, mem_ld_mar = 0, mem_ld_mdr = 0, mem_mio_en = 0, mem_rw = 0;
  logic [15:0] sram_rdata = '0;
  logic        kb_valid = 0, disp_ack = 0;
  logic [7:0]  kb_data = '0;
  logic        bus_drv = 0;
  logic [15:0] bus_val = '0;
  wire  [15:0] bus;
  logic        mem_rdy, sram_en, sram_we, disp_valid, kb_irq, disp_irq, mcr_run;
  logic [15:0] sram_addr, sram_wdata;
  logic [7:0]  disp_data;

  assign bus = bus_drv ? bus_val : 16'hzzzz;

  mem_ctrl #(.MEM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .gate_mdr(gate_mdr),
    .mem_ld_mar(mem_ld_mar), .mem_ld_mdr(mem_ld_mdr), .mem_mio_en(mem_mio_en),
    .mem_rw(mem_rw), .mem_rdy(mem_rdy), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .kb_valid(kb_valid), .kb_data(kb_data), .disp_valid(disp_valid),
    .disp_data(disp_data), .disp_ack(disp_ack), .kb_irq(kb_irq),
    .disp_irq(disp_irq), .mcr_run(mcr_run));

  // Second instance at the minimum latency
  logic        mio1 = 0;
  wire  [15:0] bus1;
  logic        rdy1, en1, we1, dv1, kirq1, dirq1, run1;
  logic [15:0] addr1, wdata1;
  logic [7:0]  dd1;
  assign bus1 = 16'h0000;

  mem_ctrl #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .gate_mdr(1'b0),
    .mem_ld_mar(1'b0), .mem_ld_mdr(1'b0), .mem_mio_en(mio1),
    .mem_rw(1'b0), .mem_rdy(rdy1), .sram_en(en1), .sram_we(we1),
    .sram_addr(addr1), .sram_wdata(wdata1), .sram_rdata(16'h0),
    .kb_valid(1'b0), .kb_data(8'h00), .disp_valid(dv1),
    .disp_data(dd1), .disp_ack(1'b0), .kb_irq(kirq1),
    .disp_irq(dirq1), .mcr_run(run1));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic chk_en = 0;
  logic rnd_en = 0;
  int we_cnt = 0;
  logic [15:0] we_addr = '0, we_data = '0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_mar, m_mdr, m_snap, m_kbdr, m_ddr, m_mcr;
  logic        m_kf, m_kie, m_dr, m_die, m_dv, m_rdy, m_we, m_acc;
  int          m_start, cycn = 0;
  logic        mf, mclr, mrdy0;
  logic [15:0] mmar0, mmdr0;

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a < 16'hFE00) return sram_rdata;
    case (a)
      16'hFE00: return {m_kf, m_kie, 14'h0};
      16'hFE02: return m_kbdr;
      16'hFE04: return {m_dr, m_die, 14'h0};
      16'hFE06: return m_ddr;
      16'hFFFE: return m_mcr;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mar = 0; m_mdr = 0; m_snap = 0; m_kbdr = 0; m_ddr = 0; m_mcr = 16'h8000;
      m_kf = 0; m_kie = 0; m_dr = 1; m_die = 0; m_dv = 0;
      m_rdy = 0; m_we = 0; m_acc = 0; m_start = 0;
    end else begin
      mrdy0 = m_rdy; mmar0 = m_mar; mmdr0 = m_mdr;
      // an access completes exactly L edges after mio_en was first seen
      mf = m_acc && mem_mio_en && !m_rdy && (cycn - m_start == L);
      m_we = mf && mem_rw && (mmar0 < 16'hFE00);
      if (mf) m_snap = m_read(mmar0);
      mclr = mf && !mem_rw && (mmar0 == 16'hFE02);
      if (kb_valid && (!m_kf || mclr)) begin
        m_kbdr = {8'h00, kb_data}; m_kf = 1;
      end else if (mclr) m_kf = 0;
      if (mf && mem_rw && mmar0 == 16'hFE00) m_kie = mmdr0[14];
      if (mf && mem_rw && mmar0 == 16'hFE04) m_die = mmdr0[14];
      if (mf && mem_rw && mmar0 == 16'hFFFE) m_mcr = mmdr0;
      if (mf && mem_rw && mmar0 == 16'hFE06) begin
        m_ddr = mmdr0; m_dv = 1; m_dr = 0;
      end else if (disp_ack && m_dv) begin
        m_dv = 0; m_dr = 1;
      end
      if (mem_ld_mar) m_mar = bus_val;
      if (mem_ld_mdr) begin
        if (!mem_mio_en || mem_rw) m_mdr = bus_val;
        else if (mrdy0) m_mdr = m_snap;
      end
      if (!mem_mio_en) begin
        m_acc = 0; m_rdy = 0;
      end else if (!m_acc) begin
        m_acc = 1; m_start = cycn;
      end else if (mf) m_rdy = 1;
      cycn++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_rdy", 16'(mem_rdy), 16'(m_rdy));
      chk("sram_en", 16'(sram_en), 16'(m_acc && (m_mar < 16'hFE00)));
      chk("sram_we", 16'(sram_we), 16'(m_we));
      chk("sram_addr", sram_addr, m_mar);
      chk("sram_wdata", sram_wdata, m_mdr);
      chk("disp_valid", 16'(disp_valid), 16'(m_dv));
      chk("disp_data", 16'(disp_data), 16'(m_ddr[7:0]));
      chk("kb_irq", 16'(kb_irq), 16'(m_kf & m_kie));
      chk("disp_irq", 16'(disp_irq), 16'(m_dr & m_die));
      chk("mcr_run", 16'(mcr_run), 16'(m_mcr[15]));
      if (gate_mdr) chk("bus", bus, m_mdr);
    end
    if (sram_we) begin
      we_cnt++; we_addr = sram_addr; we_data = sram_wdata;
    end
  end

  // random background events
  initial forever begin
    @(posedge clk); #2;
    if (rnd_en) begin
      kb_valid   = ($urandom % 4 == 0);
      kb_data    = 8'($urandom);
      disp_ack   = ($urandom % 3 == 0);
      sram_rdata = 16'($urandom);
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic access(input logic [15:0] a, input logic w, input logic [15:0] d,
                        input int hold, input int abort_after, input logic kbfire,
                        input logic gate, output int lat);
    int n;
    gate_mdr = 0;
    bus_drv = 1; bus_val = a; mem_ld_mar = 1; cyc();
    mem_ld_mar = 0;
    if (w) begin bus_val = d; mem_ld_mdr = 1; cyc(); mem_ld_mdr = 0; end
    bus_drv = 0; mem_rw = w; mem_ld_mdr = !w; mem_mio_en = 1; gate_mdr = gate;
    lat = 0;
    if (abort_after > 0) begin
      repeat (abort_after) cyc();
    end else begin
      n = 0;
      while (!mem_rdy && n < 40) begin
        if (kbfire) begin kb_valid = (n == L); kb_data = 8'h42; end
        cyc(); n++;
      end
      if (kbfire) kb_valid = 0;
      if (!mem_rdy) chk("rdy_timeout", 16'(mem_rdy), 16'h1);
      lat = n - 1;
      cyc();
      repeat (hold) cyc();
    end
    mem_mio_en = 0; mem_ld_mdr = 0; gate_mdr = 0; mem_rw = 0; cyc();
  endtask

  task automatic rd(input logic [15:0] a, output int lat);
    access(a, 1'b0, 16'h0, 0, 0, 1'b0, 1'b0, lat);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    int lat;
    access(a, 1'b1, d, 0, 0, 1'b0, 1'b0, lat);
  endtask

  initial begin
    int lat, w0;
    logic [15:0] a, rdm;
    #1 rst_n = 0;
    repeat (3) cyc();
    rst_n = 1;
    chk_en = 1;
    cyc();
    chk("rst_addr", sram_addr, 16'h0000);
    chk("rst_mdr", sram_wdata, 16'h0000);
    chk("rst_rdy", 16'(mem_rdy), 16'h0);
    chk("rst_dv", 16'(disp_valid), 16'h0);
    chk("rst_run", 16'(mcr_run), 16'h1);

    bus_drv = 1; bus_val = 16'h3000; mem_ld_mar = 1; cyc();
    mem_ld_mar = 0; bus_drv = 0;
    chk("mar_load", sram_addr, 16'h3000);
    rd(16'hFE00, lat); chk("kbsr_rst", sram_wdata, 16'h0000);
    rd(16'hFE04, lat); chk("dsr_rst", sram_wdata, 16'h8000);
    rd(16'hFFFE, lat); chk("mcr_rst", sram_wdata, 16'h8000);
    chk("dv_rst", 16'(disp_valid), 16'h0);

    sram_rdata = 16'h1234;
    rd(16'h3000, lat);
    chk("latency", 16'(lat), 16'(L));
    chk("ram_rd", sram_wdata, 16'h1234);
    gate_mdr = 1; #1;
    chk("gate_bus", bus, 16'h1234);
    gate_mdr = 0;

    w0 = we_cnt;
    access(16'h4000, 1'b1, 16'hBEEF, 3, 0, 1'b0, 1'b0, lat);
    chk("we_count", 16'(we_cnt - w0), 16'h1);
    chk("we_addr", we_addr, 16'h4000);
    chk("we_data", we_data, 16'hBEEF);

    kb_data = 8'h41; kb_valid = 1; cyc(); kb_valid = 0;
    rd(16'hFE00, lat); chk("kbsr_full", sram_wdata, 16'h8000);
    kb_data = 8'h42; kb_valid = 1; cyc(); kb_valid = 0;
    rd(16'hFE02, lat); chk("kbdr_first", sram_wdata, 16'h0041);
    rd(16'hFE00, lat); chk("kbsr_clr", sram_wdata, 16'h0000);
    kb_data = 8'h43; kb_valid = 1; cyc(); kb_valid = 0;
    access(16'hFE02, 1'b0, 16'h0, 0, 0, 1'b1, 1'b0, lat);
    chk("kbdr_old", sram_wdata, 16'h0043);
    rd(16'hFE00, lat); chk("kbsr_stay", sram_wdata, 16'h8000);
    rd(16'hFE02, lat); chk("kbdr_new", sram_wdata, 16'h0042);

    wr(16'hFE04, 16'h4000);
    wr(16'hFE06, 16'h0061);
    chk("dv_set", 16'(disp_valid), 16'h1);
    chk("disp_data", 16'(disp_data), 16'h0061);
    chk("dirq_busy", 16'(disp_irq), 16'h0);
    rd(16'hFE04, lat); chk("dsr_busy", sram_wdata, 16'h4000);
    disp_ack = 1; cyc(); disp_ack = 0;
    chk("dv_ack", 16'(disp_valid), 16'h0);
    chk("dirq_ack", 16'(disp_irq), 16'h1);
    rd(16'hFE04, lat); chk("dsr_ack", sram_wdata, 16'hC000);

    w0 = we_cnt;
    bus_drv = 1; bus_val = 16'h5000; mem_ld_mar = 1; cyc();
    mem_ld_mar = 0; bus_val = 16'h1111; mem_ld_mdr = 1; cyc();
    mem_ld_mdr = 0; bus_drv = 0; mem_rw = 1; mem_mio_en = 1;
    repeat (3) cyc();
    rst_n = 0; mem_mio_en = 0; mem_rw = 0; cyc();
    chk("rstab_rdy", 16'(mem_rdy), 16'h0);
    chk("rstab_en", 16'(sram_en), 16'h0);
    chk("rstab_mar", sram_addr, 16'h0000);
    rst_n = 1; repeat (L + 2) cyc();
    chk("rstab_nowe", 16'(we_cnt - w0), 16'h0);
    chk("rstab_rdy2", 16'(mem_rdy), 16'h0);

    mio1 = 1; cyc();
    chk("l1_edgeN", 16'(rdy1), 16'h0);
    cyc();
    chk("l1_edgeN1", 16'(rdy1), 16'h1);
    mio1 = 0; cyc();
    chk("l1_drop", 16'(rdy1), 16'h0);

    rnd_en = 1;
    for (int i = 0; i < 100; i++) begin
      case ($urandom % 8)
        0, 1:    a = 16'($urandom % 32'hFE00);
        2:       a = 16'hFE00;
        3:       a = 16'hFE02;
        4:       a = 16'hFE04;
        5:       a = 16'hFE06;
        6:       a = 16'hFFFE;
        default: a = 16'hFE10;
      endcase
      rdm = 16'($urandom);
      access(a, 1'($urandom), rdm, int'($urandom % 4),
             ($urandom % 5 == 0) ? int'($urandom_range(L - 1, 1)) : 0,
             1'b0, 1'($urandom), lat);
    end
    rnd_en = 0; #1;
    kb_valid = 0; disp_ack = 0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
